// File: rtl/calc3_core.sv
// calc3_core: per-port two-beat request capture, per-port FIFOs, round-robin shared ALU.
// Optional rotate commands are enabled by defining CALC3_ROTATE_EN.
module calc3_core #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
  input  logic [TAG_W*NUM_PORTS-1:0]  req_tag_in,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [2*NUM_PORTS-1:0]      out_resp,
  output logic [DATA_W*NUM_PORTS-1:0] out_data,
  output logic [TAG_W*NUM_PORTS-1:0]  out_tag
);
  localparam int SHW = $clog2(DATA_W);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int EW  = 4 + TAG_W + 2*DATA_W;
  localparam logic [CW-1:0] CNT_LIM = CW'(FIFO_DEPTH - 1);

  typedef enum logic {S_IDLE, S_OP2} cap_state_t;

  cap_state_t            state_q [NUM_PORTS];
  cap_state_t            state_d [NUM_PORTS];
  logic [3:0]            cap_cmd [NUM_PORTS];
  logic [TAG_W-1:0]      cap_tag [NUM_PORTS];
  logic [DATA_W-1:0]     cap_op1 [NUM_PORTS];
  logic [EW-1:0]         fifo_mem [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr  [NUM_PORTS];
  logic [AW-1:0]         rd_ptr  [NUM_PORTS];
  logic [CW-1:0]         cnt_q   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  take;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  pop;
  logic                  rdy_en;
  logic [PW-1:0]         rr_ptr;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt_idx;

  logic                  vld_p0;
  logic [PW-1:0]         port_p0;
  logic [EW-1:0]         ent_p0;
  logic [3:0]            cmd_p0;
  logic [TAG_W-1:0]      tag_p0;
  logic [DATA_W-1:0]     op1_p0;
  logic [DATA_W-1:0]     op2_p0;
  logic [DATA_W+1:0]     res_p0;

  // Returns {resp, data}; any failing or unknown command collapses to resp 2 with zero data.
  function automatic logic [DATA_W+1:0] alu_eval(input logic [3:0] cmd,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [SHW-1:0]    sh;
    logic [1:0]        resp;
    logic [DATA_W-1:0] res;
`ifdef CALC3_ROTATE_EN
    logic [2*DATA_W-1:0] rot;
    rot  = '0;
`endif
    sh   = b[SHW-1:0];
    sum  = {1'b0, a} + {1'b0, b};
    resp = 2'd2;
    res  = '0;
    case (cmd)
      4'h1: if (!sum[DATA_W]) begin resp = 2'd1; res = sum[DATA_W-1:0]; end
      4'h2: if (b <= a) begin resp = 2'd1; res = a - b; end
      4'h5: begin resp = 2'd1; res = a << sh; end
      4'h6: begin resp = 2'd1; res = a >> sh; end
`ifdef CALC3_ROTATE_EN
      4'h7: begin rot = {a, a} << sh; resp = 2'd1; res = rot[2*DATA_W-1:DATA_W]; end
      4'h8: begin rot = {a, a} >> sh; resp = 2'd1; res = rot[DATA_W-1:0]; end
`endif
      default: begin resp = 2'd2; res = '0; end
    endcase
    return {resp, res};
  endfunction

  // Capture FSMs and ready generation
  always_comb begin
    req_ready = '0;
    take      = '0;
    push      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p]   = state_q[p];
      req_ready[p] = rdy_en && (state_q[p] == S_IDLE) && (cnt_q[p] < CNT_LIM);
      case (state_q[p])
        S_IDLE: if (req_ready[p] && (req_cmd_in[4*p +: 4] != 4'h0)) begin
          take[p]    = 1'b1;
          state_d[p] = S_OP2;
        end
        S_OP2: begin
          push[p]    = 1'b1;
          state_d[p] = S_IDLE;
        end
        default: state_d[p] = S_IDLE;
      endcase
    end
  end

  // Round-robin grant over non-empty FIFOs, search starting at rr_ptr
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pop     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_vld && (cnt_q[(int'(rr_ptr) + i) % NUM_PORTS] != '0)) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      end
    end
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rdy_en <= 1'b0;
      rr_ptr <= '0;
      vld_p0 <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= S_IDLE;
        wr_ptr[p]  <= '0;
        rd_ptr[p]  <= '0;
        cnt_q[p]   <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      vld_p0 <= gnt_vld;
      if (gnt_vld) rr_ptr <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        case ({push[p], pop[p]})
          2'b10:   cnt_q[p] <= cnt_q[p] + 1'b1;
          2'b01:   cnt_q[p] <= cnt_q[p] - 1'b1;
          default: cnt_q[p] <= cnt_q[p];
        endcase
      end
    end
  end

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (take[p]) begin
        cap_cmd[p] <= req_cmd_in[4*p +: 4];
        cap_tag[p] <= req_tag_in[TAG_W*p +: TAG_W];
        cap_op1[p] <= req_data_in[DATA_W*p +: DATA_W];
      end
      if (push[p])
        fifo_mem[p][wr_ptr[p]] <= {cap_cmd[p], cap_tag[p], cap_op1[p], req_data_in[DATA_W*p +: DATA_W]};
    end
    if (gnt_vld) begin
      ent_p0  <= fifo_mem[gnt_idx][rd_ptr[gnt_idx]];
      port_p0 <= gnt_idx;
    end
  end

  // Stage p0 -> outputs: evaluate the granted entry and steer it to its own port
  assign cmd_p0 = ent_p0[EW-1 -: 4];
  assign tag_p0 = ent_p0[2*DATA_W +: TAG_W];
  assign op1_p0 = ent_p0[DATA_W +: DATA_W];
  assign op2_p0 = ent_p0[0 +: DATA_W];
  assign res_p0 = alu_eval(cmd_p0, op1_p0, op2_p0);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      if (vld_p0) begin
        out_resp[2*int'(port_p0) +: 2]           <= res_p0[DATA_W+1:DATA_W];
        out_data[DATA_W*int'(port_p0) +: DATA_W] <= res_p0[DATA_W-1:0];
        out_tag[TAG_W*int'(port_p0) +: TAG_W]    <= tag_p0;
      end
    end
  end

endmodule

// File: doc/calc3_core.md
CALC3_CORE -- requirements
Module: calc3_core

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of request/response ports (1..8).
REQ-002 SHALL have parameter DATA_W, default 32: operand/result width (power of 2, 8..64).
REQ-003 SHALL have parameter TAG_W, default 2: tag width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2: per-port request queue depth (power of 2, >=2).
REQ-005 c_clk  input  1  sole clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 req_cmd_in  input  4*NUM_PORTS  per-port command; port p uses bits [4p+3:4p].
REQ-008 req_data_in  input  DATA_W*NUM_PORTS  per-port operand bus.
REQ-009 req_tag_in  input  TAG_W*NUM_PORTS  per-port request tag.
REQ-010 req_ready  output  NUM_PORTS  port p may start a request this cycle.
REQ-011 out_resp  output  2*NUM_PORTS  per-port response: 0 none, 1 success, 2 error, 3 never driven.
REQ-012 out_data  output  DATA_W*NUM_PORTS  per-port result.
REQ-013 out_tag  output  TAG_W*NUM_PORTS  per-port echoed tag.

Function
REQ-014 Commands SHALL be: 4'h0 no-op, 4'h1 add, 4'h2 sub, 4'h5 shift left, 4'h6 shift right (logical); all other nonzero values are invalid.
REQ-015 Each port SHALL run a capture FSM, IDLE -> OP2 -> IDLE: nonzero cmd sampled in IDLE with req_ready=1 captures cmd, tag and operand1; the next edge captures operand2 (cmd/tag ignored) and pushes {cmd,tag,op1,op2} into the port FIFO.
REQ-016 req_ready[p] SHALL be 1 only when port p is IDLE and its FIFO holds fewer than FIFO_DEPTH-1 entries (guarantees room for the in-flight push); nonzero cmd while req_ready=0 SHALL be ignored.
REQ-017 A shared ALU SHALL grant one non-empty FIFO per cycle, round-robin, starting search at last granted port+1; pointer holds when nothing is granted.
REQ-018 An entry pushed at edge k SHALL be eligible for grant at edge k+1; the granted entry is popped and its result registered onto out_* of its own port at the following edge (minimum: response visible 2 cycles after the operand2 edge).
REQ-019 out_resp[p] SHALL be nonzero for exactly one cycle per request; out_data/out_tag valid only in that cycle, otherwise 0.
REQ-020 Add SHALL give resp 1 with DATA_W-bit sum; carry out of bit DATA_W-1 gives resp 2, data 0.
REQ-021 Sub SHALL give resp 1 with op1-op2; op2>op1 gives resp 2, data 0.
REQ-022 Shifts SHALL shift op1 by op2[log2(DATA_W)-1:0], resp 1; upper op2 bits ignored.
REQ-023 Invalid cmd SHALL give resp 2, data 0, tag echoed.
REQ-024 Responses per port SHALL be in request order; tags are passed through, never checked.
REQ-025 Simultaneous push and pop on one FIFO SHALL both take effect; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 reset=0 SHALL immediately clear all out_* and req_ready to 0, empty all FIFOs, force all FSMs to IDLE, set round-robin pointer to port 0.
REQ-027 Requests partially captured, queued or in the ALU at reset assertion SHALL be discarded with no response.
REQ-028 req_ready SHALL rise at the first rising edge after reset deasserts.

Configuration
REQ-029 With CALC3_ROTATE_EN defined, cmd 4'h7 SHALL rotate op1 left and 4'h8 rotate right by op2[log2(DATA_W)-1:0], resp 1.
REQ-030 Without CALC3_ROTATE_EN, 4'h7 and 4'h8 SHALL be invalid (resp 2, data 0) and no rotate logic SHALL be synthesised.

Verification (NUM_PORTS=4, DATA_W=32, TAG_W=2, FIFO_DEPTH=2)
REQ-031 Port0 add, op1 0x30, op2 0x20, tag 1 -> out_resp[0]=1, data 0x50, tag 1, exactly 2 cycles after operand2 edge, one cycle wide.
REQ-032 Port1 add 0xFFFFFFFF+0x1 -> resp 2, data 0; port1 sub 0x10-0x20 -> resp 2; port1 shl 0x1 by 0x24 -> resp 1, data 0x10.
REQ-033 All four ports issue add 1+1 on the same edge, tags 0..3 -> responses on ports 0,1,2,3 in four consecutive cycles, data 0x2, tags matching.
REQ-034 Port2 cmd 4'hF, tag 3 -> resp 2, data 0, tag 3; cmd 4'h7 op1 0x80000000 op2 1 -> resp 1 data 0x1 with CALC3_ROTATE_EN, resp 2 data 0 without.
REQ-035 reset driven low between operand1 and operand2 on port3 -> all outputs 0 immediately, no response after release, req_ready[3]=1 one edge after release.
